// File: rtl/ro_cache_pkg.sv
// Shared definitions for the read-only cache controller.
//  - RO_MAX_RD_PORTS : upper bound on accelerator read ports
//  - rd_port_id_t    : container wide enough for any read-port ID
//  - calc_id_width() : ID width for a given port count (minimum 1 bit)
package ro_cache_pkg;
  localparam int RO_MAX_RD_PORTS = 16;

  typedef logic [$clog2(RO_MAX_RD_PORTS)-1:0] rd_port_id_t;

  function automatic int calc_id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ro_cache_rr_arb.sv
// N-way round-robin arbiter with grant lock.
//  clk, rst        : clock, synchronous active-high reset
//  req_i[N]        : per-port request
//  hold_i          : grant offered but not taken; freeze it for next cycle
//  accept_i        : grant taken this cycle; advance the pointer
//  gnt_vld_o       : some port is granted
//  gnt_id_o        : granted port
// Build option: RO_RD_MUX_PORT0_PRIO_EN gives port 0 absolute priority;
// ports 1..N-1 keep rotating and a port-0 grant leaves the pointer alone.
module ro_cache_rr_arb
  import ro_cache_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = calc_id_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          hold_i,
  input  logic          accept_i,
  output logic          gnt_vld_o,
  output logic [IW-1:0] gnt_id_o
);
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] lock_id_q;
  logic          lock_q;
  logic [IW-1:0] pick_id;
  logic          pick_vld;
  int            idx;

  // First requester at or after the pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    idx      = 0;
`ifdef RO_RD_MUX_PORT0_PRIO_EN
    if (req_i[0]) pick_vld = 1'b1;
`endif
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!pick_vld && req_i[idx]) begin
        pick_vld = 1'b1;
        pick_id  = IW'(idx);
      end
    end
  end

  // A held grant keeps address and winner stable until the handshake,
  // even if a higher-ranked requester shows up meanwhile.
  assign gnt_vld_o = lock_q | pick_vld;
  assign gnt_id_o  = lock_q ? lock_id_q : pick_id;

  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
`ifdef RO_RD_MUX_PORT0_PRIO_EN
      if (gnt_id_o != '0)
`endif
        ptr_d = (gnt_id_o == IW'(N - 1)) ? '0 : gnt_id_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      lock_q <= hold_i;
      if (hold_i) lock_id_q <= gnt_id_o;
    end
  end
endmodule

// File: rtl/ro_cache_rd_port_mux.sv
// Read-port front end of the read-only cache controller.
// Arbitrates NUM_PORTS accelerator read requests onto one cache lookup port,
// remembers each lookup's requester in an in-order route FIFO, and steers
// returned data plus a per-port done pulse back to the requester.
//  clk, rst               : clock, synchronous active-high reset
//  acc_rd_valid/ready/addr: per-port request handshake (addr packed per port)
//  acc_rd_data            : shared response data (holds when idle)
//  acc_rd_data_valid      : one-hot response strobe, 1 cycle after return
//  acc_rd_done            : port's last in-flight lookup returned (pulse)
//  cache_rd_*             : lookup request / in-order data return
//  err_unexpected_rsp     : sticky, data returned with nothing in flight
// Build option: RO_RD_MUX_PORT0_PRIO_EN (see ro_cache_rr_arb).
module ro_cache_rd_port_mux
  import ro_cache_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            acc_rd_valid,
  output logic [NUM_PORTS-1:0]            acc_rd_ready,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] acc_rd_addr,
  output logic [DATA_WIDTH-1:0]           acc_rd_data,
  output logic [NUM_PORTS-1:0]            acc_rd_data_valid,
  output logic [NUM_PORTS-1:0]            acc_rd_done,
  output logic                            cache_rd_valid,
  input  logic                            cache_rd_ready,
  output logic [ADDR_WIDTH-1:0]           cache_rd_addr,
  input  logic [DATA_WIDTH-1:0]           cache_rd_data,
  input  logic                            cache_rd_data_valid,
  output logic                            err_unexpected_rsp
);
  localparam int IW = calc_id_width(NUM_PORTS);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic          gnt_vld;
  logic [IW-1:0] gnt_id;
  logic          push, pop, hold, fifo_full, fifo_empty;
  logic [IW-1:0] head;

  logic [IW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;

  logic [NUM_PORTS-1:0][CW-1:0] outst_q, outst_d;
  logic [NUM_PORTS-1:0]         dv_q, dv_d, done_q, done_d;
  logic [DATA_WIDTH-1:0]        data_q, data_d;
  logic                         err_q, err_d;

  ro_cache_rr_arb #(.N(NUM_PORTS)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (acc_rd_valid),
    .hold_i   (hold),
    .accept_i (push),
    .gnt_vld_o(gnt_vld),
    .gnt_id_o (gnt_id)
  );

  assign fifo_full  = (cnt_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (cnt_q == '0);
  assign head       = fifo_q[rd_q];

  // Full blocks the grant outright, even with a same-cycle pop, so the
  // response return never lands on the request path.
  assign cache_rd_valid = gnt_vld && !fifo_full && !rst;
  assign cache_rd_addr  = cache_rd_valid ?
                          acc_rd_addr[int'(gnt_id)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign push = cache_rd_valid && cache_rd_ready;
  assign hold = cache_rd_valid && !cache_rd_ready;
  assign pop  = cache_rd_data_valid && !fifo_empty && !rst;

  always_comb begin
    acc_rd_ready = '0;
    if (push) acc_rd_ready[gnt_id] = 1'b1;
  end

  // Per-port in-flight counts and response steering.
  always_comb begin
    outst_d = outst_q;
    dv_d    = '0;
    done_d  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      logic inc, dec;
      inc = push && (gnt_id == IW'(i));
      dec = pop  && (head   == IW'(i));
      if (inc && !dec)      outst_d[i] = outst_q[i] + 1'b1;
      else if (dec && !inc) outst_d[i] = outst_q[i] - 1'b1;
      if (dec) dv_d[i] = 1'b1;
      if (dec && !inc && outst_q[i] == CW'(1)) done_d[i] = 1'b1;
    end
  end

  assign data_d = pop ? cache_rd_data : data_q;
  assign err_d  = err_q | (cache_rd_data_valid && fifo_empty);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      outst_q <= '0;
      dv_q    <= '0;
      done_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_q] <= gnt_id;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
      outst_q <= outst_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign acc_rd_data        = data_q;
  assign acc_rd_data_valid  = dv_q;
  assign acc_rd_done        = done_q;
  assign err_unexpected_rsp = err_q;
endmodule
